axemis_cluster_apb_router: RTL and testbench

Parametrised, registered APB 1-to-N router for the AXEMIS cluster. It decodes one upstream APB completer port to NUM_SLV downstream requester ports using a base/mask table per port. Unmapped addresses get an internal error response, and an optional timeout watchdog aborts hung slaves. It sits between the cluster APB ingress and the per-core AXEMIS and MMU-TCU register blocks, and breaks the combinational PREADY/PRDATA path into registered stages.

---
 rtl/axemis_cluster_apb_pkg.sv | 34 +++
 rtl/axemis_cluster_apb_decode.sv | 31 +++
 rtl/axemis_cluster_apb_router.sv | 167 ++++++++++++++++
 tb/tb_axemis_cluster_apb_router.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axemis_cluster_apb_pkg.sv
// rtl/axemis_cluster_apb_pkg.sv - shared FSM state type, default decode tables and table slice helper
package axemis_cluster_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  localparam int DEF_NUM_SLV = 9;
  localparam int DEF_ADDR_W  = 32;
  localparam int MAX_SLV     = 16;
  localparam int MAX_ADDR_W  = 64;
  localparam int MAX_TBL_W   = MAX_SLV * MAX_ADDR_W;

  // Ports 0..7 take one 1 MiB window each; port 8 owns the upper half of the first 16 MiB.
  localparam logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
    32'h0080_0000, 32'h0070_0000, 32'h0060_0000, 32'h0050_0000, 32'h0040_0000,
    32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000
  };

  localparam logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] DEF_SLV_MASK = {
    32'hFF80_0000, {8{32'hFFF0_0000}}
  };

  function automatic logic [MAX_ADDR_W-1:0] tbl_slice(input logic [MAX_TBL_W-1:0] tbl,
                                                      input int idx, input int w);
    logic [MAX_TBL_W-1:0] s;
    s = tbl >> (idx * w);
    return s[MAX_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/axemis_cluster_apb_decode.sv
// rtl/axemis_cluster_apb_decode.sv - combinational base/mask address decoder, lowest matching port wins
module axemis_cluster_apb_decode
  import axemis_cluster_apb_pkg::*;
#(
  parameter int NUM_SLV = 9,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = (NUM_SLV*ADDR_W)'(DEF_SLV_BASE),
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = (NUM_SLV*ADDR_W)'(DEF_SLV_MASK)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [MAX_TBL_W-1:0] BASE_EXT = MAX_TBL_W'(SLV_BASE);
  localparam logic [MAX_TBL_W-1:0] MASK_EXT = MAX_TBL_W'(SLV_MASK);

  // Scan from the top so the last (lowest-index) match is the one that sticks.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & ADDR_W'(tbl_slice(MASK_EXT, i, ADDR_W))) == ADDR_W'(tbl_slice(BASE_EXT, i, ADDR_W))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axemis_cluster_apb_router.sv
// rtl/axemis_cluster_apb_router.sv - registered APB 1-to-N router; AXMSCL_APB_TIMEOUT_EN adds an ACCESS watchdog
module axemis_cluster_apb_router
  import axemis_cluster_apb_pkg::*;
#(
  parameter int NUM_SLV  = 9,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = (NUM_SLV*ADDR_W)'(DEF_SLV_BASE),
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = (NUM_SLV*ADDR_W)'(DEF_SLV_MASK),
  parameter int TOUT_CYC = 256
) (
  input  logic                      AXMSCL_PCLK,
  input  logic                      AXMSCL_PRST,
  input  logic [ADDR_W-1:0]         AXMSCL_PADDR,
  input  logic                      AXMSCL_PSELX,
  input  logic                      AXMSCL_PENABLE,
  input  logic                      AXMSCL_PWRITE,
  input  logic [2:0]                AXMSCL_PPROT,
  input  logic [DATA_W/8-1:0]       AXMSCL_PSTRB,
  input  logic [DATA_W-1:0]         AXMSCL_PWDATA,
  output logic                      AXMSCL_PREADY,
  output logic                      AXMSCL_PSLVERR,
  output logic [DATA_W-1:0]         AXMSCL_PRDATA,
  output logic [ADDR_W-1:0]         M_PADDR,
  output logic                      M_PWRITE,
  output logic [2:0]                M_PPROT,
  output logic [DATA_W/8-1:0]       M_PSTRB,
  output logic [DATA_W-1:0]         M_PWDATA,
  output logic                      M_PENABLE,
  output logic [NUM_SLV-1:0]        M_PSELX,
  input  logic [NUM_SLV-1:0]        M_PREADY,
  input  logic [NUM_SLV-1:0]        M_PSLVERR,
  input  logic [NUM_SLV*DATA_W-1:0] M_PRDATA,
  output logic                      AXMSCL_TOUT_PULSE
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  apb_state_e         state_q, state_d;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ready, sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               accept, finish, abort;

  axemis_cluster_apb_decode #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (AXMSCL_PADDR),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign sel_ready = M_PREADY[sel_idx];
  assign sel_err   = M_PSLVERR[sel_idx];
  assign sel_rdata = M_PRDATA[int'(sel_idx)*DATA_W +: DATA_W];

`ifdef AXMSCL_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TOUT_CYC + 1);
  logic [CNT_W-1:0] tout_cnt;
  logic             tout_pulse_q;

  always_ff @(posedge AXMSCL_PCLK or negedge AXMSCL_PRST) begin
    if (!AXMSCL_PRST) begin
      tout_cnt <= '0;
    end else if (state_q == ST_SETUP) begin
      tout_cnt <= '0;
    end else if (state_q == ST_ACCESS && !sel_ready) begin
      tout_cnt <= tout_cnt + 1'b1;
    end
  end

  always_ff @(posedge AXMSCL_PCLK or negedge AXMSCL_PRST) begin
    if (!AXMSCL_PRST) tout_pulse_q <= 1'b0;
    else              tout_pulse_q <= abort;
  end

  assign AXMSCL_TOUT_PULSE = tout_pulse_q;
`else
  logic unused_tout_cfg;
  assign unused_tout_cfg   = (TOUT_CYC == 0);
  assign AXMSCL_TOUT_PULSE = 1'b0;
`endif

  always_ff @(posedge AXMSCL_PCLK or negedge AXMSCL_PRST) begin
    if (!AXMSCL_PRST) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (AXMSCL_PSELX && !AXMSCL_PENABLE) begin
          accept  = 1'b1;
          state_d = dec_hit ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          finish  = 1'b1;
          state_d = ST_RESP;
        end
`ifdef AXMSCL_APB_TIMEOUT_EN
        else if (tout_cnt == CNT_W'(TOUT_CYC - 1)) begin
          abort   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every upstream/downstream output comes from a flop so no combinational path crosses the router.
  always_ff @(posedge AXMSCL_PCLK or negedge AXMSCL_PRST) begin
    if (!AXMSCL_PRST) begin
      AXMSCL_PREADY  <= 1'b0;
      AXMSCL_PSLVERR <= 1'b0;
      AXMSCL_PRDATA  <= '0;
      M_PADDR        <= '0;
      M_PWRITE       <= 1'b0;
      M_PPROT        <= '0;
      M_PSTRB        <= '0;
      M_PWDATA       <= '0;
      M_PENABLE      <= 1'b0;
      M_PSELX        <= '0;
      sel_idx        <= '0;
    end else begin
      if (state_q == ST_RESP) AXMSCL_PREADY <= 1'b0;
      if (state_q == ST_SETUP) M_PENABLE <= 1'b1;
      if (accept) begin
        M_PADDR  <= AXMSCL_PADDR;
        M_PWRITE <= AXMSCL_PWRITE;
        M_PPROT  <= AXMSCL_PPROT;
        M_PSTRB  <= AXMSCL_PSTRB;
        M_PWDATA <= AXMSCL_PWDATA;
        sel_idx  <= dec_idx;
        if (dec_hit) begin
          M_PSELX <= NUM_SLV'(1) << dec_idx;
        end else begin
          AXMSCL_PREADY  <= 1'b1;
          AXMSCL_PSLVERR <= 1'b1;
          AXMSCL_PRDATA  <= '0;
        end
      end
      if (finish || abort) begin
        M_PSELX        <= '0;
        M_PENABLE      <= 1'b0;
        AXMSCL_PREADY  <= 1'b1;
        AXMSCL_PSLVERR <= abort ? 1'b1 : sel_err;
        AXMSCL_PRDATA  <= (abort || M_PWRITE) ? '0 : sel_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axemis_cluster_apb_router.sv
// tb/tb_axemis_cluster_apb_router.sv - randomized self-checking bench for axemis_cluster_apb_router (AXMSCL_APB_TIMEOUT_EN aware)
module tb_axemis_cluster_apb_router;

  localparam int NSLV = 9;
  localparam int TOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       up_paddr;
  logic              up_psel, up_penable, up_pwrite;
  logic [2:0]        up_pprot;
  logic [3:0]        up_pstrb;
  logic [31:0]       up_pwdata;
  logic              up_pready, up_pslverr;
  logic [31:0]       up_prdata;
  logic [31:0]       m_paddr;
  logic              m_pwrite;
  logic [2:0]        m_pprot;
  logic [3:0]        m_pstrb;
  logic [31:0]       m_pwdata;
  logic              m_penable;
  logic [NSLV-1:0]   m_psel;
  logic [NSLV-1:0]   m_pready;
  logic [NSLV-1:0]   m_pslverr;
  logic [NSLV*32-1:0] m_prdata;
  logic              tout_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axemis_cluster_apb_router #(.TOUT_CYC(TOUT)) dut (
    .AXMSCL_PCLK       (clk),
    .AXMSCL_PRST       (rst_n),
    .AXMSCL_PADDR      (up_paddr),
    .AXMSCL_PSELX      (up_psel),
    .AXMSCL_PENABLE    (up_penable),
    .AXMSCL_PWRITE     (up_pwrite),
    .AXMSCL_PPROT      (up_pprot),
    .AXMSCL_PSTRB      (up_pstrb),
    .AXMSCL_PWDATA     (up_pwdata),
    .AXMSCL_PREADY     (up_pready),
    .AXMSCL_PSLVERR    (up_pslverr),
    .AXMSCL_PRDATA     (up_prdata),
    .M_PADDR           (m_paddr),
    .M_PWRITE          (m_pwrite),
    .M_PPROT           (m_pprot),
    .M_PSTRB           (m_pstrb),
    .M_PWDATA          (m_pwdata),
    .M_PENABLE         (m_penable),
    .M_PSELX           (m_psel),
    .M_PREADY          (m_pready),
    .M_PSLVERR         (m_pslverr),
    .M_PRDATA          (m_prdata),
    .AXMSCL_TOUT_PULSE (tout_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map as ranges: 1 MiB windows for ports 0..7, then 8 MiB for port 8, else unmapped.
  function automatic int ref_port(input logic [31:0] a);
    if (a < 32'h0080_0000)      return int'(a >> 20);
    else if (a < 32'h0100_0000) return 8;
    else                        return -1;
  endfunction

  task automatic check_all_reset(input string tag);
    check({tag, "_pready"},  up_pready, 0);
    check({tag, "_pslverr"}, up_pslverr, 0);
    check({tag, "_prdata"},  up_prdata, 0);
    check({tag, "_m_psel"},  m_psel, 0);
    check({tag, "_m_pen"},   m_penable, 0);
    check({tag, "_m_paddr"}, m_paddr, 0);
    check({tag, "_m_pwdat"}, m_pwdata, 0);
    check({tag, "_m_pstrb"}, m_pstrb, 0);
    check({tag, "_m_pprot"}, m_pprot, 0);
    check({tag, "_m_pwr"},   m_pwrite, 0);
    check({tag, "_tout"},    tout_pulse, 0);
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < NSLV; i++) begin
      m_prdata[i*32 +: 32] = $urandom;
      m_pslverr[i]         = 1'($urandom);
      m_pready[i]          = 1'b1;
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input int wait_n, input logic serr,
                      input logic [31:0] rd, input logic drop);
    int p, n, lat;
    logic [NSLV-1:0] oh;
    logic [2:0] pr;
    p   = ref_port(a);
    lat = (p < 0) ? 1 : 3 + wait_n;
    oh  = (p < 0) ? '0 : (NSLV'(1) << p);
    pr  = 3'($urandom);
    fill_garbage();
    if (p >= 0) begin
      m_pready[p]          = 1'b0;
      m_pslverr[p]         = serr;
      m_prdata[p*32 +: 32] = rd;
    end
    up_paddr = a; up_pwrite = wr; up_pwdata = wd; up_pstrb = st; up_pprot = pr;
    up_psel = 1'b1; up_penable = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        up_penable = 1'b1;
        if (drop) up_psel = 1'b0;
        check("setup_m_psel", m_psel, oh);
        if (p >= 0) begin
          check("setup_m_pen",   m_penable, 0);
          check("setup_m_paddr", m_paddr, a);
          check("setup_m_pwr",   m_pwrite, wr);
          check("setup_m_pwdat", m_pwdata, wd);
          check("setup_m_pstrb", m_pstrb, st);
          check("setup_m_pprot", m_pprot, pr);
        end
      end
      if (p >= 0 && n == 2) begin
        check("access_m_pen",  m_penable, 1);
        check("access_m_psel", m_psel, oh);
      end
      if (p >= 0 && n >= 2 + wait_n) m_pready[p] = 1'b1;
    end while (!up_pready && n < lat + 20);
    check("latency",     64'(n), 64'(lat));
    check("resp_pready", up_pready, 1);
    check("resp_err",    up_pslverr, (p < 0) ? 1'b1 : serr);
    check("resp_rdata",  up_prdata, (p < 0 || wr) ? 32'h0 : rd);
    check("resp_m_psel", m_psel, 0);
    check("resp_m_pen",  m_penable, 0);
    check("resp_tout",   tout_pulse, 0);
    up_psel = 1'b0; up_penable = 1'b0;
    @(posedge clk); #1;
    check("pready_one_cycle", up_pready, 0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    int r;
    rst_n = 1'b0;
    up_paddr = '0; up_psel = 1'b0; up_penable = 1'b0; up_pwrite = 1'b0;
    up_pprot = '0; up_pstrb = '0; up_pwdata = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    #1;
    check_all_reset("rst");
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_reset("post_rst");

    xfer(32'h0030_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678, 1'b0);
    xfer(32'h0080_0004, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer(32'h0100_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b0);
    xfer(32'h0020_0100, 1'b0, 32'h0, 4'h0, 4, 1'b1, 32'h0BAD_0002, 1'b0);
    xfer(32'h007F_FFFC, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h7777_0007, 1'b0);
    xfer(32'h00FF_FFFC, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h8888_0008, 1'b1);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = (32'(r) << 20) | (32'($urandom) & 32'h000F_FFFF);
      else if (r == 8) a = 32'h0080_0000 | (32'($urandom) & 32'h007F_FFFF);
      else             a = {8'($urandom_range(1, 255)), 24'($urandom)};
      xfer(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 5)),
           1'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Port 5 never answers.
    fill_garbage();
    m_pready[5] = 1'b0;
    m_prdata[5*32 +: 32] = 32'hCAFE_0005;
    up_paddr = 32'h0050_0040; up_pwrite = 1'b0; up_psel = 1'b1; up_penable = 1'b0;
    n = 0;
`ifdef AXMSCL_APB_TIMEOUT_EN
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) up_penable = 1'b1;
    end while (!up_pready && n < 200);
    check("tout_latency", 64'(n), 64'(2 + TOUT));
    check("tout_pulse",   tout_pulse, 1);
    check("tout_err",     up_pslverr, 1);
    check("tout_rdata",   up_prdata, 0);
    check("tout_m_psel",  m_psel, 0);
    check("tout_m_pen",   m_penable, 0);
    up_psel = 1'b0; up_penable = 1'b0;
    @(posedge clk); #1;
    check("tout_pulse_end", tout_pulse, 0);
    check("tout_pready_end", up_pready, 0);
`else
    r = 0;
    repeat (1000) begin
      @(posedge clk); #1; n++;
      if (n == 1) up_penable = 1'b1;
      if (n > 1 && (up_pready || tout_pulse || m_psel != (NSLV'(1) << 5) || !m_penable)) r++;
    end
    check("hang_still_waiting", 64'(r), 64'(0));
    m_pready[5] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!up_pready && n < 20);
    check("hang_release_lat", 64'(n), 64'(1));
    check("hang_release_rd",  up_prdata, 32'hCAFE_0005);
    check("hang_release_err", up_pslverr, m_pslverr[5]);
    up_psel = 1'b0; up_penable = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset dropped while the downstream access is in progress.
    fill_garbage();
    m_pready[4] = 1'b0;
    up_paddr = 32'h0040_0008; up_pwrite = 1'b1; up_pwdata = 32'h1357_9BDF;
    up_pstrb = 4'hF; up_pprot = 3'h5; up_psel = 1'b1; up_penable = 1'b0;
    @(posedge clk); #1; up_penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_m_pen", m_penable, 1);
    rst_n = 1'b0;
    #1;
    check_all_reset("mid_rst");
    @(posedge clk); #1;
    check("mid_rst_held_pready", up_pready, 0);
    rst_n = 1'b1; up_psel = 1'b0; up_penable = 1'b0;
    @(posedge clk); #1;
    check("after_rst_pready", up_pready, 0);
    xfer(32'h0060_0020, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h6666_6666, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
